// File: rtl/mult_accumulate_frame_stream.sv
// mult_accumulate_frame_stream: pipelined unsigned MAC summing fixed-length frames, results drained over valid/ready
module mult_accumulate_frame_stream #(
    parameter int A_W       = 20,
    parameter int B_W       = 18,
    parameter int ACC_W     = 38,
    parameter int FRAME_LEN = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [A_W-1:0]   a,
    input  logic [B_W-1:0]   b,
    input  logic             op,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [ACC_W-1:0] z_out,
    output logic             z_valid,
    input  logic             z_ready
);
    localparam int CNT_W = $clog2(FRAME_LEN);

    logic [A_W-1:0]     r_a;
    logic [B_W-1:0]     r_b;
    logic               r_op;
    logic               r_v1;
    logic [ACC_W-1:0]   r_p;
    logic               r_op2;
    logic               r_v2;
    logic [ACC_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic [ACC_W-1:0]   r_z_out;
    logic               r_z_valid;
    logic               w_stall;
    logic [A_W+B_W-1:0] w_prod;
    logic [ACC_W-1:0]   w_next;
    logic               w_last;

    assign w_stall  = r_z_valid & ~z_ready;
    assign in_ready = ~w_stall;
    assign z_out    = r_z_out;
    assign z_valid  = r_z_valid;
    assign w_prod   = {{B_W{1'b0}}, r_a} * {{A_W{1'b0}}, r_b};
    assign w_next   = r_op2 ? r_acc - r_p : r_acc + r_p;
    assign w_last   = r_cnt == CNT_W'(FRAME_LEN - 1);

    // input register: capture a sample whenever one is offered and not stalled
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a  <= '0;
            r_b  <= '0;
            r_op <= 1'b0;
            r_v1 <= 1'b0;
        end else if (in_valid && !w_stall) begin
            r_a  <= a;
            r_b  <= b;
            r_op <= op;
            r_v1 <= 1'b1;
        end else if (!w_stall) begin
            r_v1 <= 1'b0;
        end
    end

    // product register: multiply the captured operands, zero-extended to accumulator width
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_p   <= '0;
            r_op2 <= 1'b0;
            r_v2  <= 1'b0;
        end else if (!w_stall) begin
            r_p   <= ACC_W'(w_prod);
            r_op2 <= r_op;
            r_v2  <= r_v1;
        end
    end

    // accumulate products; on the last product of a frame publish the total and restart from zero
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc     <= '0;
            r_cnt     <= '0;
            r_z_out   <= '0;
            r_z_valid <= 1'b0;
        end else begin
            if (r_z_valid && z_ready)
                r_z_valid <= 1'b0;
            if (r_v2 && !w_stall) begin
                if (w_last) begin
                    r_z_out   <= w_next;
                    r_z_valid <= 1'b1;
                    r_acc     <= '0;
                    r_cnt     <= '0;
                end else begin
                    r_acc <= w_next;
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_mult_accumulate_frame_stream.sv
// tb_mult_accumulate_frame_stream: vector table, directed corner sequences and scoreboarded random traffic
module tb_mult_accumulate_frame_stream;
    localparam int A_W = 20, B_W = 18, ACC_W = 38, FL = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [A_W-1:0]   a = '0;
    logic [B_W-1:0]   b = '0;
    logic             op = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [ACC_W-1:0] z_out;
    logic             z_valid;
    logic             z_ready = 1'b0;

    int errors = 0;
    int checks = 0;

    logic [ACC_W-1:0] exp_q[$];
    logic [ACC_W-1:0] m_acc = '0;
    int               m_cnt = 0;

    typedef struct packed {
        logic [FL-1:0][A_W-1:0] sa;
        logic [FL-1:0][B_W-1:0] sb;
        logic [FL-1:0]          sop;
        logic                   bubbles;
        logic [ACC_W-1:0]       exp;
    } row_t;

    row_t rows [6];

    mult_accumulate_frame_stream #(.A_W(A_W), .B_W(B_W), .ACC_W(ACC_W), .FRAME_LEN(FL)) dut (
        .clk(clk), .reset(reset), .a(a), .b(b), .op(op), .in_valid(in_valid),
        .in_ready(in_ready), .z_out(z_out), .z_valid(z_valid), .z_ready(z_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [ACC_W-1:0] act, input logic [ACC_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // reference model and scoreboard, evaluated mid-cycle where inputs and outputs are stable
    always @(negedge clk) begin
        if (reset) begin
            m_acc = '0;
            m_cnt = 0;
            exp_q.delete();
        end else begin
            if (z_valid && z_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected: got %0d expected no output", z_out);
                end else begin
                    check("sb_total", z_out, exp_q.pop_front());
                end
            end
            if (in_valid && in_ready) begin
                logic [ACC_W-1:0] prod;
                prod = {{B_W{1'b0}}, a} * {{A_W{1'b0}}, b};
                m_acc = op ? m_acc - prod : m_acc + prod;
                if (m_cnt == FL - 1) begin
                    exp_q.push_back(m_acc);
                    m_acc = '0;
                    m_cnt = 0;
                end else begin
                    m_cnt++;
                end
            end
        end
    end

    task automatic send(input logic [A_W-1:0] ta, input logic [B_W-1:0] tb, input logic top);
        int n = 0;
        a = ta;
        b = tb;
        op = top;
        in_valid = 1'b1;
        #0;
        while (!in_ready && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready got 0 expected 1");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_zv(input string name);
        int n = 0;
        while (!z_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!z_valid) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: z_valid got 0 expected 1", name);
        end
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check("rst_z_out", z_out, 0);
        check("rst_z_valid", ACC_W'(z_valid), 0);
        check("rst_in_ready", ACC_W'(in_ready), 1);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        rows[0] = '{sa: {20'd3, 20'd3, 20'd3, 20'd3}, sb: {18'd5, 18'd5, 18'd5, 18'd5},
                    sop: 4'b0000, bubbles: 1'b0, exp: 38'd60};
        rows[1] = '{sa: {20'd0, 20'd0, 20'd0, 20'h7ffff}, sb: {18'd5, 18'd5, 18'd5, 18'h1ffff},
                    sop: 4'b0001, bubbles: 1'b0, exp: 38'd206159085567};
        rows[2] = '{sa: {20'hfffff, 20'hfffff, 20'hfffff, 20'hfffff}, sb: {18'h3ffff, 18'h3ffff, 18'h3ffff, 18'h3ffff},
                    sop: 4'b0000, bubbles: 1'b0, exp: 38'd274872664068};
        rows[3] = '{sa: {20'hfffff, 20'hfffff, 20'hfffff, 20'hfffff}, sb: {18'h3ffff, 18'h3ffff, 18'h3ffff, 18'h3ffff},
                    sop: 4'b0000, bubbles: 1'b1, exp: 38'd274872664068};
        rows[4] = '{sa: {20'd1, 20'd100, 20'd7, 20'd10}, sb: {18'd50, 18'd2, 18'd3, 18'd10},
                    sop: 4'b1010, bubbles: 1'b1, exp: 38'd229};
        rows[5] = '{sa: {20'd0, 20'd0, 20'd2, 20'd1}, sb: {18'd0, 18'd0, 18'd1, 18'd1},
                    sop: 4'b0010, bubbles: 1'b0, exp: 38'h3fffffffff};

        #1;
        check("init_z_out", z_out, 0);
        check("init_z_valid", ACC_W'(z_valid), 0);
        check("init_in_ready", ACC_W'(in_ready), 1);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("idle_z_valid", ACC_W'(z_valid), 0);
        end

        z_ready = 1'b1;
        for (int i = 0; i < FL; i++) send(3, 5, 0);
        in_valid = 1'b0;
        check("lat_k0", ACC_W'(z_valid), 0);
        @(posedge clk);
        #1;
        check("lat_k1", ACC_W'(z_valid), 0);
        @(posedge clk);
        #1;
        check("lat_k2_valid", ACC_W'(z_valid), 1);
        check("lat_k2_z_out", z_out, 60);
        @(posedge clk);
        #1;
        check("lat_k3_valid", ACC_W'(z_valid), 0);

        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < FL; i++) begin
                send(rows[r].sa[i], rows[r].sb[i], rows[r].sop[i]);
                if (rows[r].bubbles && i < FL - 1) begin
                    in_valid = 1'b0;
                    repeat (2) @(posedge clk);
                    #1;
                end
            end
            in_valid = 1'b0;
            wait_zv($sformatf("row%0d", r));
            check($sformatf("row%0d_z_out", r), z_out, rows[r].exp);
            @(posedge clk);
            #1;
        end

        z_ready = 1'b0;
        for (int i = 0; i < FL; i++) send(2, 3, 0);
        in_valid = 1'b0;
        wait_zv("bp");
        check("bp_z_out", z_out, 24);
        a = 5;
        b = 5;
        op = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("bp_in_ready", ACC_W'(in_ready), 0);
            check("bp_hold_z_out", z_out, 24);
            check("bp_hold_valid", ACC_W'(z_valid), 1);
        end
        z_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_valid", ACC_W'(z_valid), 0);
        check("bp_release_ready", ACC_W'(in_ready), 1);
        for (int i = 0; i < FL; i++) send(5, 5, 0);
        in_valid = 1'b0;
        wait_zv("bp_next");
        check("bp_next_z_out", z_out, 100);
        @(posedge clk);
        #1;

        z_ready = 1'b0;
        for (int i = 0; i < FL; i++) send(1, 1, 0);
        in_valid = 1'b0;
        wait_zv("held");
        do_reset();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("post_rst_valid", ACC_W'(z_valid), 0);
        end

        z_ready = 1'b1;
        send(9, 9, 0);
        send(9, 9, 1);
        do_reset();
        for (int i = 0; i < FL; i++) send(1, 1, 0);
        in_valid = 1'b0;
        wait_zv("midrst");
        check("midrst_z_out", z_out, 4);
        @(posedge clk);
        #1;

        begin
            int acc_n = 0;
            int cyc = 0;
            while (acc_n < 600 && cyc < 5000) begin
                a = A_W'($urandom);
                b = B_W'($urandom);
                op = 1'($urandom);
                in_valid = $urandom_range(0, 4) != 0;
                z_ready = $urandom_range(0, 2) != 0;
                #1;
                if (in_valid && in_ready) acc_n++;
                @(posedge clk);
                #1;
                cyc++;
            end
            check("rand_accepted", ACC_W'(acc_n), 600);
        end
        in_valid = 1'b0;
        z_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("sb_empty", ACC_W'(exp_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
